// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: decodes 4-byte command frames (SYNC, CMD, ARG, CHK) from the
// uart_rx byte stream. It updates the PWM duty and LED registers and answers each
// frame with ACK/NAK (plus a data byte for reads) over the uart_tx handshake.
module uart_cmd_parser #(
   parameter int         NUM_CH         = 4,
   parameter int         TIMEOUT_CYCLES = 80_000,
   parameter logic [7:0] SYNC_BYTE      = 8'hA5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [7:0]            rx_data,
   input  logic                  rx_valid,
   output logic [7:0]            tx_data,
   output logic                  tx_valid,
   input  logic                  tx_busy,
   output logic [NUM_CH*8-1:0]   duty,
   output logic [5:0]            led_ctrl,
   output logic                  frame_err,
   output logic                  rx_drop
);

   localparam logic [7:0] ACK_BYTE = 8'h06;
   localparam logic [7:0] NAK_BYTE = 8'h15;
   localparam logic [7:0] CMD_DUTY = 8'h10;
   localparam logic [7:0] CMD_READ = 8'h20;
   localparam logic [7:0] CMD_LED  = 8'h30;
   localparam int         TW       = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE,
      GET_CMD,
      GET_ARG,
      GET_CHK,
      EXEC,
      SEND,
      WAIT_BUSY_HI,
      WAIT_BUSY_LO
   } state_t;

   logic [1:0]          rstSync_q;
   logic                rstInt_n;

   state_t              state_q;
   logic [7:0]          cmd_q;
   logic [7:0]          arg_q;
   logic [7:0]          chk_q;
   logic [NUM_CH*8-1:0] duty_q;
   logic [5:0]          led_q;
   logic [7:0]          txData_q;
   logic                txValid_q;
   logic                frameErr_q;
   logic                rxDrop_q;
   logic [TW-1:0]       tout_q;
   logic [1:0]          hiCnt_q;
   logic [7:0]          reply_q;
   logic [7:0]          second_q;
   logic                pending_q;

   logic                chkOk_d;
   logic                cmdOk_d;
   logic                isRead_d;
   logic                isLed_d;
   logic                readOk_d;
   logic [NUM_CH-1:0]   dutyWr_d;
   logic [7:0]          rdByte_d;

   // Reset asserts immediately but is released only after two clean clock edges,
   // so the whole parser leaves reset on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rstSync_q <= 2'b00;
      end else begin
         rstSync_q <= {rstSync_q[0], 1'b1};
      end
   end

   assign rstInt_n = rstSync_q[1];

   // Decode of the captured frame. Only EXEC consumes these results.
   always_comb begin
      chkOk_d  = ((cmd_q ^ arg_q) == chk_q);
      isRead_d = (cmd_q == CMD_READ);
      isLed_d  = (cmd_q == CMD_LED);
      readOk_d = isRead_d && (arg_q < 8'(NUM_CH));
      dutyWr_d = '0;
      rdByte_d = 8'h00;
      for (int i = 0; i < NUM_CH; i++) begin
         if (cmd_q == 8'(int'(CMD_DUTY) + i)) begin
            dutyWr_d[i] = 1'b1;
         end
         if (arg_q == 8'(i)) begin
            rdByte_d = duty_q[8*i +: 8];
         end
      end
      cmdOk_d = (|dutyWr_d) || isRead_d || isLed_d;
   end

   // Frame FSM. All outputs are registered; the pulse outputs default low each cycle.
   always_ff @(posedge clk or negedge rstInt_n) begin
      if (!rstInt_n) begin
         state_q    <= IDLE;
         cmd_q      <= 8'h00;
         arg_q      <= 8'h00;
         chk_q      <= 8'h00;
         duty_q     <= '0;
         led_q      <= 6'h00;
         txData_q   <= 8'h00;
         txValid_q  <= 1'b0;
         frameErr_q <= 1'b0;
         rxDrop_q   <= 1'b0;
         tout_q     <= '0;
         hiCnt_q    <= 2'd0;
         reply_q    <= 8'h00;
         second_q   <= 8'h00;
         pending_q  <= 1'b0;
      end else begin
         txValid_q  <= 1'b0;
         frameErr_q <= 1'b0;
         rxDrop_q   <= 1'b0;
         case (state_q)
            IDLE: begin
               tout_q <= '0;
               if (rx_valid && (rx_data == SYNC_BYTE)) begin
                  state_q <= GET_CMD;
               end
            end
            GET_CMD, GET_ARG, GET_CHK: begin
               if (tout_q == TOUT_LAST) begin
                  state_q    <= IDLE;
                  frameErr_q <= 1'b1;
                  tout_q     <= '0;
               end else if (rx_valid) begin
                  tout_q <= '0;
                  if (state_q == GET_CMD) begin
                     cmd_q   <= rx_data;
                     state_q <= GET_ARG;
                  end else if (state_q == GET_ARG) begin
                     arg_q   <= rx_data;
                     state_q <= GET_CHK;
                  end else begin
                     chk_q   <= rx_data;
                     state_q <= EXEC;
                  end
               end else begin
                  tout_q <= tout_q + TW'(1);
               end
            end
            EXEC: begin
               tout_q    <= '0;
               hiCnt_q   <= 2'd0;
               pending_q <= 1'b0;
               second_q  <= rdByte_d;
               if (rx_valid) begin
                  rxDrop_q <= 1'b1;
               end
               if (chkOk_d && cmdOk_d) begin
                  for (int i = 0; i < NUM_CH; i++) begin
                     if (dutyWr_d[i]) begin
                        duty_q[8*i +: 8] <= arg_q;
                     end
                  end
                  if (isLed_d) begin
                     led_q <= arg_q[5:0];
                  end
                  if (isRead_d && !readOk_d) begin
                     reply_q <= NAK_BYTE;
                  end else begin
                     reply_q <= ACK_BYTE;
                  end
                  pending_q <= readOk_d;
               end else begin
                  reply_q    <= NAK_BYTE;
                  frameErr_q <= 1'b1;
               end
               state_q <= SEND;
            end
            SEND: begin
               tout_q <= '0;
               if (rx_valid) begin
                  rxDrop_q <= 1'b1;
               end
               if (!tx_busy) begin
                  txData_q  <= reply_q;
                  txValid_q <= 1'b1;
                  hiCnt_q   <= 2'd0;
                  state_q   <= WAIT_BUSY_HI;
               end
            end
            WAIT_BUSY_HI: begin
               tout_q <= '0;
               if (rx_valid) begin
                  rxDrop_q <= 1'b1;
               end
               if (tx_busy || (hiCnt_q == 2'd3)) begin
                  state_q <= WAIT_BUSY_LO;
               end else begin
                  hiCnt_q <= hiCnt_q + 2'd1;
               end
            end
            WAIT_BUSY_LO: begin
               tout_q <= '0;
               if (rx_valid) begin
                  rxDrop_q <= 1'b1;
               end
               if (!tx_busy) begin
                  if (pending_q) begin
                     reply_q   <= second_q;
                     pending_q <= 1'b0;
                     state_q   <= SEND;
                  end else begin
                     state_q <= IDLE;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
               tout_q  <= '0;
            end
         endcase
      end
   end

   assign tx_data   = txData_q;
   assign tx_valid  = txValid_q;
   assign duty      = duty_q;
   assign led_ctrl  = led_q;
   assign frame_err = frameErr_q;
   assign rx_drop   = rxDrop_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb_uart_cmd_parser: drives command frames into uart_cmd_parser, models the
// uart_tx busy handshake and scores reply bytes against a queue of expected bytes.
module tb_uart_cmd_parser;

   localparam int TOUT = 1000;

   typedef struct {
      logic [7:0]  cmd;
      logic [7:0]  arg;
      logic [7:0]  chk;
      int          nRep;
      logic [7:0]  r0;
      logic [7:0]  r1;
      int          expErr;
      logic [31:0] expDuty;
      logic [5:0]  expLed;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_busy;
   logic [31:0] duty;
   logic [5:0]  led_ctrl;
   logic        frame_err;
   logic        rx_drop;

   int          busyLen = 6;
   int          busyCnt;
   int          totalCount = 0;
   int          badCount = 0;
   int          txCount = 0;
   int          errCount = 0;
   int          dropCount = 0;
   logic [7:0]  expQ[$];
   vec_t        vecs[13];

   uart_cmd_parser #(
      .NUM_CH(4),
      .TIMEOUT_CYCLES(TOUT),
      .SYNC_BYTE(8'hA5)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .rx_data(rx_data),
      .rx_valid(rx_valid),
      .tx_data(tx_data),
      .tx_valid(tx_valid),
      .tx_busy(tx_busy),
      .duty(duty),
      .led_ctrl(led_ctrl),
      .frame_err(frame_err),
      .rx_drop(rx_drop)
   );

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   // uart_tx stand-in: busy rises the cycle after a start strobe and stays up busyLen cycles.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busyCnt <= 0;
      end else if (tx_valid && (busyLen > 0)) begin
         busyCnt <= busyLen;
      end else if (busyCnt > 0) begin
         busyCnt <= busyCnt - 1;
      end
   end

   assign tx_busy = (busyCnt != 0);

   // Hard stop in case something hangs despite the bounded waits.
   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      totalCount++;
      if (act !== exp) begin
         badCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // One clock: sample on the falling edge and score any reply byte.
   task automatic tick();
      logic [7:0] e;
      @(negedge clk);
      if (tx_valid) begin
         txCount++;
         checkOutput("tx_while_busy", {31'b0, tx_busy}, 32'd0);
         if (expQ.size() == 0) begin
            totalCount++;
            badCount++;
            $display("[TB] FAIL tx_unexpected: got 0x%0h, expected no byte", tx_data);
         end else begin
            e = expQ.pop_front();
            checkOutput("tx_byte", {24'b0, tx_data}, {24'b0, e});
         end
      end
      if (frame_err) errCount++;
      if (rx_drop) dropCount++;
   endtask

   task automatic sendByte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
      rx_data  = 8'h00;
   endtask

   task automatic applyStimulus(input logic [7:0] cmd, input logic [7:0] arg, input logic [7:0] chk);
      sendByte(8'hA5);
      sendByte(cmd);
      sendByte(arg);
      sendByte(chk);
   endtask

   // Wait for every expected byte and the link to go quiet, then idle a little longer.
   task automatic drain(input string name);
      int n;
      n = 0;
      while ((n < 300) && ((expQ.size() != 0) || tx_busy)) begin
         tick();
         n++;
      end
      if (n >= 300) begin
         totalCount++;
         badCount++;
         $display("[TB] FAIL %s_timeout: got %0d bytes pending, expected 0", name, expQ.size());
         expQ.delete();
      end
      repeat (12) tick();
   endtask

   initial begin
      int errBase;
      int txBase;
      int dropBase;
      int n;

      vecs[0]  = '{8'h11, 8'h3C, 8'h2D, 1, 8'h06, 8'h00, 0, 32'h0000_3C80, 6'h00};
      vecs[1]  = '{8'h20, 8'h01, 8'h21, 2, 8'h06, 8'h3C, 0, 32'h0000_3C80, 6'h00};
      vecs[2]  = '{8'h10, 8'h55, 8'h44, 1, 8'h15, 8'h00, 1, 32'h0000_3C80, 6'h00};
      vecs[3]  = '{8'h13, 8'hFF, 8'hEC, 1, 8'h06, 8'h00, 0, 32'hFF00_3C80, 6'h00};
      vecs[4]  = '{8'h20, 8'h03, 8'h23, 2, 8'h06, 8'hFF, 0, 32'hFF00_3C80, 6'h00};
      vecs[5]  = '{8'h20, 8'h04, 8'h24, 1, 8'h15, 8'h00, 0, 32'hFF00_3C80, 6'h00};
      vecs[6]  = '{8'h14, 8'h55, 8'h41, 1, 8'h15, 8'h00, 1, 32'hFF00_3C80, 6'h00};
      vecs[7]  = '{8'h30, 8'h2A, 8'h1A, 1, 8'h06, 8'h00, 0, 32'hFF00_3C80, 6'h2A};
      vecs[8]  = '{8'h30, 8'hFF, 8'hCF, 1, 8'h06, 8'h00, 0, 32'hFF00_3C80, 6'h3F};
      vecs[9]  = '{8'h12, 8'hA5, 8'hB7, 1, 8'h06, 8'h00, 0, 32'hFFA5_3C80, 6'h3F};
      vecs[10] = '{8'hA5, 8'h00, 8'hA5, 1, 8'h15, 8'h00, 1, 32'hFFA5_3C80, 6'h3F};
      vecs[11] = '{8'h20, 8'h00, 8'h20, 2, 8'h06, 8'h80, 0, 32'hFFA5_3C80, 6'h3F};
      vecs[12] = '{8'h20, 8'h02, 8'h22, 2, 8'h06, 8'hA5, 0, 32'hFFA5_3C80, 6'h3F};

      rst_n    = 1'b0;
      rx_data  = 8'h00;
      rx_valid = 1'b0;
      repeat (3) tick();
      checkOutput("rst_duty", duty, 32'h0);
      checkOutput("rst_led", {26'b0, led_ctrl}, 32'h0);
      checkOutput("rst_tx_data", {24'b0, tx_data}, 32'h0);
      checkOutput("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
      checkOutput("rst_frame_err", {31'b0, frame_err}, 32'h0);
      checkOutput("rst_rx_drop", {31'b0, rx_drop}, 32'h0);
      rst_n = 1'b1;
      repeat (4) tick();

      // Write channel 0 and check the exact cycle of the update and the reply strobe.
      $display("[TB] write duty ch0 with cycle timing");
      errBase = errCount;
      txBase  = txCount;
      expQ.push_back(8'h06);
      sendByte(8'hA5);
      sendByte(8'h10);
      sendByte(8'h80);
      sendByte(8'h90);
      checkOutput("duty_before_exec", duty, 32'h0);
      tick();
      checkOutput("duty_after_exec", duty, 32'h0000_0080);
      checkOutput("tx_idle_in_exec", {31'b0, tx_valid}, 32'd0);
      tick();
      checkOutput("tx_valid_latency", {31'b0, tx_valid}, 32'd1);
      drain("write_ch0");
      checkOutput("write_ch0_err", errCount - errBase, 32'd0);
      checkOutput("write_ch0_txcount", txCount - txBase, 32'd1);

      // Table of complete frames.
      $display("[TB] table-driven frames");
      for (int v = 0; v < 13; v++) begin
         errBase = errCount;
         txBase  = txCount;
         expQ.push_back(vecs[v].r0);
         if (vecs[v].nRep == 2) expQ.push_back(vecs[v].r1);
         applyStimulus(vecs[v].cmd, vecs[v].arg, vecs[v].chk);
         drain($sformatf("vec%0d", v));
         checkOutput($sformatf("vec%0d_duty", v), duty, vecs[v].expDuty);
         checkOutput($sformatf("vec%0d_led", v), {26'b0, led_ctrl}, {26'b0, vecs[v].expLed});
         checkOutput($sformatf("vec%0d_err", v), errCount - errBase, vecs[v].expErr);
         checkOutput($sformatf("vec%0d_txcount", v), txCount - txBase, vecs[v].nRep);
      end

      // Inter-byte timeout inside a frame, then recovery.
      $display("[TB] inter-byte timeout");
      errBase = errCount;
      txBase  = txCount;
      sendByte(8'hA5);
      sendByte(8'h10);
      repeat (TOUT - 1) tick();
      checkOutput("timeout_early", errCount - errBase, 32'd0);
      tick();
      checkOutput("timeout_pulse", {31'b0, frame_err}, 32'd1);
      tick();
      checkOutput("timeout_pulse_width", {31'b0, frame_err}, 32'd0);
      expQ.push_back(8'h06);
      applyStimulus(8'h30, 8'h15, 8'h25);
      drain("after_timeout");
      checkOutput("after_timeout_led", {26'b0, led_ctrl}, 32'h15);
      checkOutput("after_timeout_duty", duty, 32'hFFA5_3C80);
      checkOutput("timeout_txcount", txCount - txBase, 32'd1);

      // Byte arriving during the reply is dropped; junk before SYNC is skipped.
      $display("[TB] rx during reply and junk before sync");
      dropBase = dropCount;
      errBase  = errCount;
      expQ.push_back(8'h06);
      applyStimulus(8'h10, 8'h44, 8'h54);
      sendByte(8'h55);
      drain("drop");
      checkOutput("drop_count", dropCount - dropBase, 32'd1);
      checkOutput("drop_duty", duty, 32'hFFA5_3C44);
      sendByte(8'h11);
      expQ.push_back(8'h06);
      applyStimulus(8'h30, 8'h01, 8'h31);
      drain("junk");
      checkOutput("junk_led", {26'b0, led_ctrl}, 32'h01);
      checkOutput("junk_drop_count", dropCount - dropBase, 32'd1);
      checkOutput("junk_err", errCount - errBase, 32'd0);

      // Timeout and SYNC byte on the same edge: timeout wins, SYNC is not taken.
      $display("[TB] timeout coincident with rx byte");
      errBase = errCount;
      txBase  = txCount;
      sendByte(8'hA5);
      repeat (TOUT - 1) tick();
      sendByte(8'hA5);
      sendByte(8'h30);
      sendByte(8'h07);
      sendByte(8'h37);
      drain("coincident");
      checkOutput("coincident_err", errCount - errBase, 32'd1);
      checkOutput("coincident_led", {26'b0, led_ctrl}, 32'h01);
      checkOutput("coincident_txcount", txCount - txBase, 32'd0);

      // uart_tx never raises busy: the parser must still complete both reply bytes.
      $display("[TB] busy never asserted");
      busyLen = 0;
      txBase  = txCount;
      expQ.push_back(8'h06);
      applyStimulus(8'h30, 8'h3F, 8'h0F);
      drain("nobusy_led");
      checkOutput("nobusy_led", {26'b0, led_ctrl}, 32'h3F);
      expQ.push_back(8'h06);
      expQ.push_back(8'h3C);
      applyStimulus(8'h20, 8'h01, 8'h21);
      drain("nobusy_read");
      checkOutput("nobusy_txcount", txCount - txBase, 32'd3);
      busyLen = 6;

      // Reset in the middle of a frame.
      $display("[TB] reset mid-frame");
      sendByte(8'hA5);
      sendByte(8'h10);
      rst_n = 1'b0;
      #1;
      checkOutput("rst_arg_duty", duty, 32'h0);
      checkOutput("rst_arg_led", {26'b0, led_ctrl}, 32'h0);
      checkOutput("rst_arg_tx_data", {24'b0, tx_data}, 32'h0);
      checkOutput("rst_arg_tx_valid", {31'b0, tx_valid}, 32'h0);
      tick();
      tick();
      rst_n = 1'b1;
      repeat (4) tick();
      txBase = txCount;
      sendByte(8'h80);
      sendByte(8'h90);
      drain("post_reset_junk");
      checkOutput("post_reset_idle_tx", txCount - txBase, 32'd0);
      checkOutput("post_reset_duty", duty, 32'h0);

      // Reset while waiting for uart_tx to finish the reply byte.
      $display("[TB] reset mid-reply");
      txBase = txCount;
      expQ.push_back(8'h06);
      applyStimulus(8'h30, 8'h21, 8'h11);
      n = 0;
      while ((n < 20) && (txCount == txBase)) begin
         tick();
         n++;
      end
      n = 0;
      while ((n < 20) && !tx_busy) begin
         tick();
         n++;
      end
      tick();
      tick();
      checkOutput("led_before_reset", {26'b0, led_ctrl}, 32'h21);
      checkOutput("busy_before_reset", {31'b0, tx_busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      checkOutput("rst_reply_led", {26'b0, led_ctrl}, 32'h0);
      checkOutput("rst_reply_tx_data", {24'b0, tx_data}, 32'h0);
      checkOutput("rst_reply_tx_valid", {31'b0, tx_valid}, 32'h0);
      tick();
      tick();
      rst_n = 1'b1;
      repeat (4) tick();
      expQ.push_back(8'h06);
      applyStimulus(8'h11, 8'h07, 8'h16);
      drain("post_reset_frame");
      checkOutput("post_reset_frame_duty", duty, 32'h0000_0700);
      checkOutput("post_reset_frame_led", {26'b0, led_ctrl}, 32'h0);

      $display("test done: total=%0d bad=%0d", totalCount, badCount);
      $finish;
   end

endmodule
